// File: rtl/mem_operand_sequencer_pkg.sv
// Shared types and constants for the memory operand sequencer.
package mem_operand_sequencer_pkg;

    // Width of every address and data word handled by the sequencer.
    localparam int DATA_W = 64;

    // Sequencer control states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    // Operand slot index; the numeric value is also the bit position in the flag vector.
    typedef enum logic [1:0] {
        SLOT_SRC1 = 2'd0,
        SLOT_SRC2 = 2'd1,
        SLOT_DEST = 2'd2
    } slot_t;

endpackage

// File: rtl/mem_slot_select.sv
// Finds the lowest set memory-operand flag at or above the current slot.
// With include_cur=1 the current slot itself qualifies (used to pick the
// first slot of a sequence); with include_cur=0 only strictly higher slots
// qualify (used to advance after a response).
module mem_slot_select
    import mem_operand_sequencer_pkg::*;
(
    input  logic  [2:0] flags,
    input  slot_t       cur,
    input  logic        include_cur,
    output logic        found,
    output slot_t       slot
);

    // Scan from the top down so the last hit kept is the lowest qualifying slot.
    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        found = 1'b0;
        slot  = SLOT_SRC1;
        for (int i = 2; i >= 0; i--) begin
            if (flags[i] && ((i > int'(cur)) || (include_cur && (i == int'(cur))))) begin
                found = 1'b1;
                slot  = slot_t'(2'(i));
            end
        end
    end

endmodule

// File: rtl/mem_operand_sequencer.sv
// Fetches up to three memory operands (SRC1, SRC2, DEST) one at a time over a
// single shared read port, with at most one request outstanding, and presents
// the loaded values until downstream consumes them. A flush while a request is
// in flight waits for (and discards) the response before returning to IDLE.
module mem_operand_sequencer
    import mem_operand_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              startIn,
    input  logic              isMemoryAccessSrc1In,
    input  logic              isMemoryAccessSrc2In,
    input  logic              isMemoryAccessDestIn,
    input  logic [DATA_W-1:0] memoryAddressSrc1In,
    input  logic [DATA_W-1:0] memoryAddressSrc2In,
    input  logic [DATA_W-1:0] memoryAddressDestIn,
    input  logic              flushIn,
    input  logic              consumeIn,
    output logic              memReqOut,
    output logic [DATA_W-1:0] memReqAddrOut,
    input  logic              memReqGrantIn,
    input  logic              memRespValidIn,
    input  logic [DATA_W-1:0] memRespDataIn,
    output logic [DATA_W-1:0] operand1DataOut,
    output logic [DATA_W-1:0] operand2DataOut,
    output logic [DATA_W-1:0] destDataOut,
    output logic              doneOut,
    output logic              busyOut
);

    state_t            state;
    state_t            state_next;
    slot_t             slot;
    logic [2:0]        flags;
    logic [DATA_W-1:0] addr_src1;
    logic [DATA_W-1:0] addr_src2;
    logic [DATA_W-1:0] addr_dest;
    logic [DATA_W-1:0] data_src1;
    logic [DATA_W-1:0] data_src2;
    logic [DATA_W-1:0] data_dest;
    logic [DATA_W-1:0] cur_addr;

    logic [2:0]        sel_flags;
    slot_t             sel_cur;
    logic              sel_include;
    logic              sel_found;
    slot_t             sel_slot;

    logic              accept_start;
    logic              capture;

    // In IDLE the finder looks at the incoming flags from slot 0 inclusive;
    // afterwards it looks at the latched flags strictly above the current slot.
    assign sel_flags   = (state == IDLE) ? {isMemoryAccessDestIn, isMemoryAccessSrc2In, isMemoryAccessSrc1In}
                                         : flags;
    assign sel_cur     = (state == IDLE) ? SLOT_SRC1 : slot;
    assign sel_include = (state == IDLE);

    mem_slot_select u_slot_select (
        .flags       (sel_flags),
        .cur         (sel_cur),
        .include_cur (sel_include),
        .found       (sel_found),
        .slot        (sel_slot)
    );

    // Flush outranks both a new start and a response capture.
    assign accept_start = (state == IDLE) && startIn && !flushIn;
    assign capture      = (state == WAIT) && memRespValidIn && !flushIn;

    assign operand1DataOut = data_src1;
    assign operand2DataOut = data_src2;
    assign destDataOut     = data_dest;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flushIn is examined first in every state except DRAIN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flushIn) begin
                    state_next = IDLE;
                end else if (startIn) begin
                    state_next = sel_found ? REQ : DONE;
                end
            end
            REQ: begin
                if (flushIn) begin
                    state_next = memReqGrantIn ? DRAIN : IDLE;
                end else if (memReqGrantIn) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flushIn) begin
                    state_next = DRAIN;
                end else if (memRespValidIn) begin
                    state_next = sel_found ? REQ : DONE;
                end
            end
            DONE: begin
                if (flushIn || consumeIn) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (memRespValidIn) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched request parameters, slot pointer and loaded operand registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: these are a handful of flops, not a memory array, so all of them take the async reset.
        if (reset) begin
            slot      <= SLOT_SRC1;
            flags     <= '0;
            addr_src1 <= '0;
            addr_src2 <= '0;
            addr_dest <= '0;
            data_src1 <= '0;
            data_src2 <= '0;
            data_dest <= '0;
        end else if (accept_start) begin
            flags     <= {isMemoryAccessDestIn, isMemoryAccessSrc2In, isMemoryAccessSrc1In};
            addr_src1 <= memoryAddressSrc1In;
            addr_src2 <= memoryAddressSrc2In;
            addr_dest <= memoryAddressDestIn;
            data_src1 <= '0;
            data_src2 <= '0;
            data_dest <= '0;
            slot      <= sel_found ? sel_slot : SLOT_SRC1;
        end else if (capture) begin
            case (slot)
                SLOT_SRC1: data_src1 <= memRespDataIn;
                SLOT_SRC2: data_src2 <= memRespDataIn;
                SLOT_DEST: data_dest <= memRespDataIn;
                default:   ;
            endcase
            if (sel_found) begin
                slot <= sel_slot;
            end
        end
    end

    // Address of the slot currently being fetched.
    always_comb begin
        cur_addr = '0;
        case (slot)
            SLOT_SRC1: cur_addr = addr_src1;
            SLOT_SRC2: cur_addr = addr_src2;
            SLOT_DEST: cur_addr = addr_dest;
            default:   cur_addr = '0;
        endcase
    end

    // Outputs decoded purely from state, so reset clears them without a clock edge.
    always_comb begin
        memReqOut     = 1'b0;
        memReqAddrOut = '0;
        doneOut       = 1'b0;
        busyOut       = 1'b1;
        case (state)
            IDLE: busyOut = 1'b0;
            REQ: begin
                memReqOut     = 1'b1;
                memReqAddrOut = cur_addr;
            end
            DONE:    doneOut = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_operand_sequencer.sv
// Scoreboard bench for mem_operand_sequencer. The driver pushes the expected
// request addresses and loaded operand values for each sequence; a memory-port
// process grants requests, returns data and compares what the DUT presents.
module tb_mem_operand_sequencer;

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] dest;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        startIn;
    logic        isMemoryAccessSrc1In;
    logic        isMemoryAccessSrc2In;
    logic        isMemoryAccessDestIn;
    logic [63:0] memoryAddressSrc1In;
    logic [63:0] memoryAddressSrc2In;
    logic [63:0] memoryAddressDestIn;
    logic        flushIn;
    logic        consumeIn;
    logic        memReqOut;
    logic [63:0] memReqAddrOut;
    logic        memReqGrantIn;
    logic        memRespValidIn;
    logic [63:0] memRespDataIn;
    logic [63:0] operand1DataOut;
    logic [63:0] operand2DataOut;
    logic [63:0] destDataOut;
    logic        doneOut;
    logic        busyOut;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_addr_q[$];
    res_t        exp_res_q[$];

    // Memory-port behaviour knobs and event counters.
    int          gw_mode    = 0;
    int          rd_mode    = 0;
    bit          use_fixed  = 1'b0;
    bit          garbage_en = 1'b0;
    logic [63:0] fixed_data = 64'h0;
    logic [63:0] salt       = 64'h0;
    int          req_cycles = 0;
    int          grant_cnt  = 0;
    int          resp_cnt   = 0;

    always #5 clk = ~clk;

    mem_operand_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .startIn              (startIn),
        .isMemoryAccessSrc1In (isMemoryAccessSrc1In),
        .isMemoryAccessSrc2In (isMemoryAccessSrc2In),
        .isMemoryAccessDestIn (isMemoryAccessDestIn),
        .memoryAddressSrc1In  (memoryAddressSrc1In),
        .memoryAddressSrc2In  (memoryAddressSrc2In),
        .memoryAddressDestIn  (memoryAddressDestIn),
        .flushIn              (flushIn),
        .consumeIn            (consumeIn),
        .memReqOut            (memReqOut),
        .memReqAddrOut        (memReqAddrOut),
        .memReqGrantIn        (memReqGrantIn),
        .memRespValidIn       (memRespValidIn),
        .memRespDataIn        (memRespDataIn),
        .operand1DataOut      (operand1DataOut),
        .operand2DataOut      (operand2DataOut),
        .destDataOut          (destDataOut),
        .doneOut              (doneOut),
        .busyOut              (busyOut)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Content the simulated memory returns for an address.
    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return use_fixed ? fixed_data : ({a[31:0], ~a[63:32]} ^ salt);
    endfunction

    // Memory port + monitor: grants, responds, and compares DUT outputs.
    bit          in_req       = 1'b0;
    int          wait_left    = 0;
    bit          resp_pending = 1'b0;
    int          resp_left    = 0;
    logic [63:0] resp_addr    = 64'h0;
    logic [63:0] held_addr    = 64'h0;

    always @(negedge clk) begin
        memRespValidIn = 1'b0;
        memRespDataIn  = {$urandom, $urandom};
        memReqGrantIn  = 1'b0;
        if (reset) begin
            in_req       = 1'b0;
            resp_pending = 1'b0;
        end else begin
            if (resp_pending) begin
                if (resp_left == 0) begin
                    memRespValidIn = 1'b1;
                    memRespDataIn  = mem_data(resp_addr);
                    resp_pending   = 1'b0;
                    resp_cnt++;
                end else begin
                    resp_left--;
                end
            end else if (garbage_en && (!busyOut || doneOut || memReqOut) && ($urandom_range(0, 3) == 0)) begin
                // Stray response where none is outstanding; the DUT must ignore it.
                memRespValidIn = 1'b1;
            end

            if (memReqOut) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    held_addr = memReqAddrOut;
                    wait_left = gw_mode;
                end else begin
                    check("req_addr_stable", memReqAddrOut, held_addr);
                end
                req_cycles++;
                if (wait_left == 0) begin
                    memReqGrantIn = 1'b1;
                    in_req        = 1'b0;
                    grant_cnt++;
                    if (exp_addr_q.size() == 0) fail_now("unexpected_request");
                    else check("req_addr", memReqAddrOut, exp_addr_q.pop_front());
                    resp_pending = 1'b1;
                    resp_addr    = memReqAddrOut;
                    resp_left    = rd_mode;
                end else begin
                    wait_left--;
                end
            end else begin
                in_req = 1'b0;
                check("addr_zero_outside_req", memReqAddrOut, 64'h0);
            end

            if (doneOut) begin
                if (exp_res_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    check("operand1", operand1DataOut, exp_res_q[0].op1);
                    check("operand2", operand2DataOut, exp_res_q[0].op2);
                    check("dest",     destDataOut,     exp_res_q[0].dest);
                    if (consumeIn) void'(exp_res_q.pop_front());
                end
            end
        end
    end

    task automatic drive_start(input logic [2:0] fl, input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2);
        @(posedge clk); #1;
        startIn              = 1'b1;
        isMemoryAccessSrc1In = fl[0];
        isMemoryAccessSrc2In = fl[1];
        isMemoryAccessDestIn = fl[2];
        memoryAddressSrc1In  = a0;
        memoryAddressSrc2In  = a1;
        memoryAddressDestIn  = a2;
        req_cycles           = 0;
        @(posedge clk); #1;
        // Scramble the inputs so only latched values can be used from here on.
        startIn              = 1'b0;
        isMemoryAccessSrc1In = $urandom_range(0, 1) == 1;
        isMemoryAccessSrc2In = $urandom_range(0, 1) == 1;
        isMemoryAccessDestIn = $urandom_range(0, 1) == 1;
        memoryAddressSrc1In  = {$urandom, $urandom};
        memoryAddressSrc2In  = {$urandom, $urandom};
        memoryAddressDestIn  = {$urandom, $urandom};
    endtask

    // One full sequence: every set slot costs (gw+1) REQ cycles plus (rd+1) WAIT cycles.
    task automatic run_txn(input logic [2:0] fl, input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] a2, input int gw, input int rd);
        res_t        r;
        logic [63:0] a[3];
        int          n = 0;
        int          k = 0;
        gw_mode = gw;
        rd_mode = rd;
        a[0] = a0;
        a[1] = a1;
        a[2] = a2;
        for (int i = 0; i < 3; i++) begin
            if (fl[i]) begin
                exp_addr_q.push_back(a[i]);
                n++;
            end
        end
        r.op1  = fl[0] ? mem_data(a0) : 64'h0;
        r.op2  = fl[1] ? mem_data(a1) : 64'h0;
        r.dest = fl[2] ? mem_data(a2) : 64'h0;
        exp_res_q.push_back(r);
        drive_start(fl, a0, a1, a2);
        do begin
            @(negedge clk);
            k++;
        end while (!doneOut && k < 300);
        if (!doneOut) begin
            fail_now("done_timeout");
        end else begin
            check("done_latency", 64'(k), 64'(1 + n * (gw + rd + 2)));
            check("req_cycles", 64'(req_cycles), 64'(n * (gw + 1)));
            check("busy_in_done", busyOut, 1'b1);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1 consumeIn = 1'b1;
        @(posedge clk); #1 consumeIn = 1'b0;
        @(negedge clk);
        check("busy_after_consume", busyOut, 1'b0);
        check("done_after_consume", doneOut, 1'b0);
    endtask

    task automatic flush_test();
        int g0;
        int r0;
        int c = 0;
        garbage_en = 1'b0;
        use_fixed  = 1'b1;
        fixed_data = 64'hAA;
        gw_mode    = 0;
        rd_mode    = 2;
        exp_addr_q.push_back(64'h4000);
        g0 = grant_cnt;
        drive_start(3'b001, 64'h4000, 64'h0, 64'h0);
        do begin
            @(posedge clk); #1;
            c++;
        end while (grant_cnt == g0 && c < 50);
        if (grant_cnt == g0) begin
            fail_now("flush_grant_timeout");
        end else begin
            // Now in WAIT with the request outstanding.
            r0      = resp_cnt;
            flushIn = 1'b1;
            @(posedge clk); #1;
            flushIn = 1'b0;
            check("busy_in_drain", busyOut, 1'b1);
            check("resp_not_yet", 64'(resp_cnt), 64'(r0));
            c = 0;
            do begin
                @(posedge clk); #1;
                c++;
            end while (busyOut && c < 50);
            check("drain_cycles", 64'(c), 64'd2);
            check("drain_resp_seen", 64'(resp_cnt), 64'(r0 + 1));
            check("drain_discard_op1", operand1DataOut, 64'h0);
            check("drain_no_done", doneOut, 1'b0);
        end
        use_fixed = 1'b0;
    endtask

    task automatic reset_test();
        int c = 0;
        garbage_en = 1'b0;
        gw_mode    = 1000;
        exp_addr_q.push_back(64'h7777);
        drive_start(3'b010, 64'h1, 64'h7777, 64'h2);
        while (!memReqOut && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("reset_test_in_req", memReqOut, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_req", memReqOut, 1'b0);
        check("async_reset_busy", busyOut, 1'b0);
        check("async_reset_done", doneOut, 1'b0);
        check("async_reset_addr", memReqAddrOut, 64'h0);
        exp_addr_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        run_txn(3'b111, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        startIn              = 1'b0;
        isMemoryAccessSrc1In = 1'b0;
        isMemoryAccessSrc2In = 1'b0;
        isMemoryAccessDestIn = 1'b0;
        memoryAddressSrc1In  = 64'h0;
        memoryAddressSrc2In  = 64'h0;
        memoryAddressDestIn  = 64'h0;
        flushIn              = 1'b0;
        consumeIn            = 1'b0;
        memReqGrantIn        = 1'b0;
        memRespValidIn       = 1'b0;
        memRespDataIn        = 64'h0;
        salt                 = {$urandom, $urandom};

        repeat (2) @(negedge clk);
        check("rst_req",   memReqOut,       1'b0);
        check("rst_busy",  busyOut,         1'b0);
        check("rst_done",  doneOut,         1'b0);
        check("rst_addr",  memReqAddrOut,   64'h0);
        check("rst_op1",   operand1DataOut, 64'h0);
        check("rst_op2",   operand2DataOut, 64'h0);
        check("rst_dest",  destDataOut,     64'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Single SRC2 operand, immediate grant, data back two cycles after grant.
        use_fixed  = 1'b1;
        fixed_data = 64'h55;
        run_txn(3'b010, 64'hDEAD, 64'h1000, 64'hBEEF, 0, 1);
        use_fixed  = 1'b0;

        // All three slots in order, each grant held off for two cycles.
        run_txn(3'b111, 64'h10, 64'h20, 64'h30, 2, 1);

        // No memory operands: straight to DONE, previous data cleared.
        run_txn(3'b000, 64'h10, 64'h20, 64'h30, 0, 0);

        flush_test();
        reset_test();

        // Randomized sequences with stray responses on the port.
        garbage_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            run_txn(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        garbage_en = 1'b0;

        repeat (3) @(negedge clk);
        check("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
        check("result_queue_empty", 64'(exp_res_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_operand_sequencer.md
MEM_OPERAND_SEQUENCER -- requirements
Module: mem_operand_sequencer

Interface
REQ-001 The block SHALL have input clk, 1 bit: the only clock; all state changes on its rising edge.
REQ-002 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have input startIn, 1 bit: a completed address calculation is present; sampled in IDLE only.
REQ-004 The block SHALL have inputs isMemoryAccessSrc1In, isMemoryAccessSrc2In and isMemoryAccessDestIn, 1 bit each: per-slot memory-operand flags.
REQ-005 The block SHALL have inputs memoryAddressSrc1In, memoryAddressSrc2In and memoryAddressDestIn, 64 bits each: per-slot effective addresses.
REQ-006 The block SHALL have input flushIn, 1 bit: abort the current sequence.
REQ-007 The block SHALL have input consumeIn, 1 bit: downstream accepts the results.
REQ-008 The block SHALL have output memReqOut, 1 bit: read request to the single shared data port.
REQ-009 The block SHALL have output memReqAddrOut, 64 bits: request address.
REQ-010 The block SHALL have input memReqGrantIn, 1 bit: port accepts the request this cycle.
REQ-011 The block SHALL have input memRespValidIn, 1 bit: read data valid.
REQ-012 The block SHALL have input memRespDataIn, 64 bits: read data.
REQ-013 The block SHALL have outputs operand1DataOut, operand2DataOut and destDataOut, 64 bits each: loaded values.
REQ-014 The block SHALL have output doneOut, 1 bit: results valid.
REQ-015 The block SHALL have output busyOut, 1 bit: stall to upstream stages.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, DONE, DRAIN. A 2-bit slot index selects SRC1 (0), SRC2 (1) or DEST (2).
REQ-017 In IDLE with startIn=1, the block SHALL latch all three flags and addresses. If any flag is set, the next state is REQ at the lowest-index set slot. If no flag is set, the next state is DONE.
REQ-018 In REQ, the block SHALL drive memReqOut=1 and memReqAddrOut = the latched address of the current slot. It SHALL hold both until memReqGrantIn=1, then go to WAIT.
REQ-019 Outside REQ, the block SHALL drive memReqOut=0 and memReqAddrOut=0.
REQ-020 In WAIT with memRespValidIn=1, the block SHALL capture memRespDataIn into the current slot register. It SHALL then go to REQ at the next higher set slot, or to DONE if none remains.
REQ-021 The block SHALL have at most one request outstanding. memRespValidIn SHALL be ignored in IDLE, REQ and DONE.
REQ-022 Per-operand latency SHALL be 1 REQ cycle minimum, plus grant wait, plus response wait. There SHALL be no extra bubble between consecutive slots.
REQ-023 In DONE, doneOut SHALL be 1 and data outputs SHALL hold. With consumeIn=1 the next state is IDLE.
REQ-024 A slot whose flag is clear SHALL read 0. Slot registers SHALL be cleared on every accepted startIn.
REQ-025 busyOut SHALL be 1 in every state except IDLE. startIn outside IDLE SHALL be ignored.
REQ-026 flushIn SHALL have priority over all other inputs:
- in IDLE, DONE, or REQ without grant: next state IDLE;
- in WAIT, or in REQ with grant in the same cycle: next state DRAIN.
REQ-027 DRAIN SHALL wait for memRespValidIn, discard the data, then go to IDLE. flushIn in DRAIN SHALL have no further effect.
REQ-028 Addresses SHALL be used unmodified (64-bit, no alignment or wrap checking).

Reset
REQ-029 On reset, the block SHALL force state=IDLE, slot=0, all data and latched registers=0, and doneOut=busyOut=memReqOut=0, asynchronously.
REQ-030 Reset asserted mid-sequence SHALL abandon any outstanding request without a drain.

Structure
REQ-031 A shared package SHALL hold the state enum, the slot enum, and the 64-bit address/data width constant.
REQ-032 One sub-module, mem_slot_select, SHALL be used: a combinational next-set-slot finder over a 3-bit flag vector and the current slot index.

Verification
REQ-033 Single operand: startIn, only Src2 flag set, addr 0x1000, grant immediately, response 0x55 two cycles later -> memReqAddrOut=0x1000 for one cycle; operand2DataOut=0x55; operand1DataOut=destDataOut=0; doneOut high.
REQ-034 All three slots, addrs 0x10/0x20/0x30, grant delayed 2 cycles each -> requests issued in order 0x10, 0x20, 0x30; each address held stable while ungranted; data lands in matching slot.
REQ-035 No flags set with startIn -> DONE one cycle later; memReqOut never asserted; all data outputs 0.
REQ-036 flushIn in WAIT, response 0xAA 3 cycles later -> DRAIN until response; 0xAA discarded; IDLE next; busyOut falls.
REQ-037 reset asserted in REQ -> memReqOut=0 and busyOut=0 immediately, without a clock edge; a later startIn begins a fresh sequence.
